// File: rtl/gunfight_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gunfight_video_pkg
// Desc     : Shared raster timing constants for the GunFight video generator.
// Revision : 1.0
// ============================================================================
package gunfight_video_pkg;

  localparam int          H_TOTAL_DEFAULT   = 320;
  localparam int          V_TOTAL_DEFAULT   = 262;
  localparam logic [12:0] VRAM_BASE_DEFAULT = 13'h0400;

  localparam logic [8:0]  H_ACTIVE       = 9'd256;
  localparam logic [8:0]  HS_START       = 9'd272;
  localparam logic [8:0]  HS_END         = 9'd303;
  localparam logic [8:0]  V_ACTIVE       = 9'd224;
  localparam logic [8:0]  VS_START       = 9'd236;
  localparam logic [8:0]  VS_END         = 9'd239;
  localparam logic [5:0]  BYTES_PER_LINE = 6'd32;

  function automatic logic in_range(input logic [8:0] x,
                                    input logic [8:0] lo,
                                    input logic [8:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gunfight_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : gunfight_raster_counter
// Desc     : H/V raster counters with registered sync/blank decode.
// Revision : 1.0
// ============================================================================
module gunfight_raster_counter
  import gunfight_video_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEFAULT,
  parameter int V_TOTAL = V_TOTAL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [8:0] h_count,
  output logic [8:0] v_count,
  output logic [8:0] h_next,
  output logic [8:0] v_next,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       hblank,
  output logic       vblank
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  logic [8:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;

  // Sync/blank decode the upcoming count so they line up with h_count/v_count.
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;
    hblank_d  = hblank_q;
    vblank_d  = vblank_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 9'd1;
      end else begin
        h_d = h_q + 9'd1;
      end
      hsync_n_d = !in_range(h_d, HS_START, HS_END);
      vsync_n_d = !in_range(v_d, VS_START, VS_END);
      hblank_d  = (h_d >= H_ACTIVE);
      vblank_d  = (v_d >= V_ACTIVE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
    end
  end

  assign h_count = h_q;
  assign v_count = v_q;
  assign h_next  = h_d;
  assign v_next  = v_d;
  assign hsync_n = hsync_n_q;
  assign vsync_n = vsync_n_q;
  assign hblank  = hblank_q;
  assign vblank  = vblank_q;

endmodule
`default_nettype wire

// File: rtl/gunfight_video_gen.sv
`default_nettype none
// ============================================================================
// Module   : gunfight_video_gen
// Desc     : Raster timing, video-RAM prefetch, LSB-first pixel shifter, IRQs.
// Revision : 1.0
// ============================================================================
module gunfight_video_gen
  import gunfight_video_pkg::*;
#(
  parameter int          H_TOTAL      = H_TOTAL_DEFAULT,
  parameter int          V_TOTAL      = V_TOTAL_DEFAULT,
  parameter logic [12:0] VRAM_BASE    = VRAM_BASE_DEFAULT,
  parameter int          IRQ_MID_LINE = 96,
  parameter int          IRQ_END_LINE = 224
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Pix_En,
  output logic [12:0] Vid_Addr,
  input  logic [7:0]  Vid_Data,
  output logic        Video,
  output logic        HSync_n,
  output logic        VSync_n,
  output logic        HBlank,
  output logic        VBlank,
  output logic        Irq_Mid,
  output logic        Irq_End,
  output logic [8:0]  HCount,
  output logic [8:0]  VCount
);

  localparam logic [8:0] H_TOT      = 9'(H_TOTAL);
  localparam logic [8:0] H_NEXTLINE = 9'(H_TOTAL - 3);
  localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
  localparam logic [8:0] MID_LINE   = 9'(IRQ_MID_LINE);
  localparam logic [8:0] END_LINE   = 9'(IRQ_END_LINE);

  logic [8:0] h_cur, v_cur, h_nxt, v_nxt;

  gunfight_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_raster (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .pix_en  (Pix_En),
    .h_count (h_cur),
    .v_count (v_cur),
    .h_next  (h_nxt),
    .v_next  (v_nxt),
    .hsync_n (HSync_n),
    .vsync_n (VSync_n),
    .hblank  (HBlank),
    .vblank  (VBlank)
  );

  logic [8:0]  h_ahead, fetch_h, fetch_line;
  logic [5:0]  fetch_col;
  logic        fetch_ok;
  logic [12:0] vid_addr_q, vid_addr_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        irq_mid_q, irq_mid_d;
  logic        irq_end_q, irq_end_d;

  // Fetch target is the byte that starts 3 pixels ahead, so the last fetch of
  // a line already points at column 0 of the following line.
  always_comb begin
    h_ahead    = h_cur + 9'd3;
    fetch_h    = (h_ahead >= H_TOT) ? h_ahead - H_TOT : h_ahead;
    fetch_col  = 6'(fetch_h >> 3);
    fetch_line = v_cur;
    if (h_cur >= H_NEXTLINE) begin
      fetch_line = (v_cur == V_LAST) ? '0 : v_cur + 9'd1;
    end
    fetch_ok = (fetch_col < BYTES_PER_LINE) && (fetch_line < V_ACTIVE);
  end

  always_comb begin
    vid_addr_d    = vid_addr_q;
    fetch_valid_d = fetch_valid_q;
    shreg_d       = shreg_q;
    irq_mid_d     = 1'b0;
    irq_end_d     = 1'b0;
    if (Pix_En) begin
      if (h_cur[2:0] == 3'd5) begin
        fetch_valid_d = fetch_ok;
        if (fetch_ok) begin
          vid_addr_d = VRAM_BASE + {fetch_line[7:0], fetch_col[4:0]};
        end
      end
      if (h_cur[2:0] == 3'd7) begin
        shreg_d = fetch_valid_q ? Vid_Data : 8'h00;
      end else begin
        shreg_d = {1'b0, shreg_q[7:1]};
      end
      irq_mid_d = (h_nxt == 9'd0) && (v_nxt == MID_LINE);
      irq_end_d = (h_nxt == 9'd0) && (v_nxt == END_LINE);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vid_addr_q    <= VRAM_BASE;
      fetch_valid_q <= 1'b0;
      shreg_q       <= 8'h00;
      irq_mid_q     <= 1'b0;
      irq_end_q     <= 1'b0;
    end else begin
      vid_addr_q    <= vid_addr_d;
      fetch_valid_q <= fetch_valid_d;
      shreg_q       <= shreg_d;
      irq_mid_q     <= irq_mid_d;
      irq_end_q     <= irq_end_d;
    end
  end

  assign Vid_Addr = vid_addr_q;
  assign Video    = shreg_q[0] & ~HBlank & ~VBlank;
  assign Irq_Mid  = irq_mid_q;
  assign Irq_End  = irq_end_q;
  assign HCount   = h_cur;
  assign VCount   = v_cur;

endmodule
`default_nettype wire

// File: tb/tb_gunfight_video_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gunfight_video_gen
// Desc     : Randomized bench for gunfight_video_gen against a raster model.
// Revision : 1.0
// ============================================================================
module tb_gunfight_video_gen;

  localparam int H_TOTAL = 320;
  localparam int V_TOTAL = 262;
  localparam int BASE    = 'h400;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Pix_En;
  logic [12:0] Vid_Addr;
  logic [7:0]  Vid_Data;
  logic        Video, HSync_n, VSync_n, HBlank, VBlank, Irq_Mid, Irq_End;
  logic [8:0]  HCount, VCount;

  logic [7:0]  mem [0:8191];

  int          n_checks = 0;
  int          n_errors = 0;
  int          mh, mv, pix_total, pix_since, max_addr;
  bit          exp_mid, exp_end;
  logic [12:0] last_addr;

  gunfight_video_gen dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Pix_En   (Pix_En),
    .Vid_Addr (Vid_Addr),
    .Vid_Data (Vid_Data),
    .Video    (Video),
    .HSync_n  (HSync_n),
    .VSync_n  (VSync_n),
    .HBlank   (HBlank),
    .VBlank   (VBlank),
    .Irq_Mid  (Irq_Mid),
    .Irq_End  (Irq_End),
    .HCount   (HCount),
    .VCount   (VCount)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read RAM: data appears one Clock after the address.
  always_ff @(posedge Clock) Vid_Data <= mem[Vid_Addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", tag, obs, exp, mh, mv);
    end
  endtask

  // Pixel H=8k+b on line V shows bit b of the bitmap byte at V*32+k; the very
  // first byte after reset is never fetched and shows as zero.
  function automatic bit exp_pixel();
    logic [7:0] b;
    if (mh >= 256 || mv >= 224 || pix_total < 8) return 1'b0;
    b = mem[13'(BASE + mv * 32 + mh / 8)];
    return b[3'(mh % 8)];
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; pix_total = 0; pix_since = 0;
    exp_mid = 1'b0; exp_end = 1'b0;
    last_addr = 13'h400;
  endtask

  task automatic check_all();
    check_eq("hcount",  32'(HCount),  32'(mh));
    check_eq("vcount",  32'(VCount),  32'(mv));
    check_eq("hblank",  32'(HBlank),  32'(mh >= 256));
    check_eq("vblank",  32'(VBlank),  32'(mv >= 224));
    check_eq("hsync_n", 32'(HSync_n), 32'(!(mh >= 272 && mh <= 303)));
    check_eq("vsync_n", 32'(VSync_n), 32'(!(mv >= 236 && mv <= 239)));
    check_eq("video",   32'(Video),   32'(exp_pixel()));
    check_eq("irq_mid", 32'(Irq_Mid), 32'(exp_mid));
    check_eq("irq_end", 32'(Irq_End), 32'(exp_end));
    if (Vid_Addr != last_addr) begin
      check_eq("addr_hold",  32'(pix_since >= 2), 32'd1);
      check_eq("addr_floor", 32'(Vid_Addr >= 13'h400), 32'd1);
      if (int'(Vid_Addr) > max_addr) max_addr = int'(Vid_Addr);
      last_addr = Vid_Addr;
      pix_since = 0;
    end
  endtask

  task automatic step(input bit en);
    Pix_En = en;
    @(posedge Clock);
    exp_mid = 1'b0;
    exp_end = 1'b0;
    if (!Reset_n) begin
      model_reset();
    end else if (en) begin
      pix_total++;
      pix_since++;
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv = (mv + 1) % V_TOTAL;
      end
      exp_mid = (mh == 0 && mv == 96);
      exp_end = (mh == 0 && mv == 224);
    end
    @(negedge Clock);
    check_all();
  endtask

  initial begin
    int         hs_low, vs_lines, mid_pulses, end_pulses, vb_rise, ff_ones;
    logic [7:0] seen;

    Reset_n = 1'b0;
    Pix_En  = 1'b0;
    max_addr = 0;
    model_reset();
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[13'h0400] = 8'hA5;
    mem[13'h1FFF] = 8'hFF;

    step(1'b0);
    step(1'b1);
    check_eq("rst_addr", 32'(Vid_Addr), 32'h400);
    Reset_n = 1'b1;

    // One full frame at full pixel rate plus frame-level tallies.
    hs_low = 0; vs_lines = 0; mid_pulses = 0; end_pulses = 0; vb_rise = -1; ff_ones = 0;
    for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
      step(1'b1);
      if (!HSync_n) hs_low++;
      if (HCount == 9'd0 && !VSync_n) vs_lines++;
      if (VBlank && vb_rise < 0) vb_rise = int'(VCount);
      if (VCount == 9'd223 && HCount >= 9'd248 && HCount < 9'd256 && Video) ff_ones++;
      if (Irq_Mid) begin
        mid_pulses++;
        check_eq("irq_mid_pos", 32'({VCount, HCount}), 32'({9'd96, 9'd0}));
      end
      if (Irq_End) begin
        end_pulses++;
        check_eq("irq_end_pos", 32'({VCount, HCount}), 32'({9'd224, 9'd0}));
      end
    end
    check_eq("frame_wrap",  32'({VCount, HCount}), 32'd0);
    check_eq("hsync_low",   32'(hs_low), 32'(32 * V_TOTAL));
    check_eq("vsync_lines", 32'(vs_lines), 32'd4);
    check_eq("vblank_rise", 32'(vb_rise), 32'd224);
    check_eq("irq_mid_cnt", 32'(mid_pulses), 32'd1);
    check_eq("irq_end_cnt", 32'(end_pulses), 32'd1);
    check_eq("last_byte",   32'(ff_ones), 32'd8);
    check_eq("addr_max",    32'(max_addr), 32'h1FFF);

    seen = '0;
    seen[0] = Video;
    for (int b = 1; b < 8; b++) begin
      step(1'b1);
      seen[b] = Video;
    end
    check_eq("line0_byte0", 32'(seen), 32'hA5);
    for (int i = 0; i < 8; i++) step(1'b1);

    // Pix_En every third Clock, then random gating.
    for (int i = 0; i < 1920; i++) step(i % 3 == 2);
    for (int i = 0; i < 1500; i++) step(1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a line.
    for (int i = 0; i < 1000 && mh != 150; i++) step(1'b1);
    check_eq("reach_h150", 32'(HCount), 32'd150);
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("mrst_hcount",  32'(HCount),   32'd0);
    check_eq("mrst_vcount",  32'(VCount),   32'd0);
    check_eq("mrst_addr",    32'(Vid_Addr), 32'h400);
    check_eq("mrst_video",   32'(Video),    32'd0);
    check_eq("mrst_sync",    32'({HSync_n, VSync_n}), 32'b11);
    check_eq("mrst_blank",   32'({HBlank, VBlank}),   32'b00);
    check_eq("mrst_irq",     32'({Irq_Mid, Irq_End}), 32'b00);
    step(1'b1);
    step(1'b1);
    Reset_n = 1'b1;
    for (int i = 0; i < 400; i++) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gunfight_video_gen.md
Name: gunfight_video_gen

Overview:
- Video timing generator and pixel shifter downstream of the 8 KB work/video RAM in the GunFight memory block.
- Generates raster counters, sync and blank, and prefetches one video-RAM byte per 8 pixels on the RAM's video read port.
- Serialises each byte LSB-first to a 1-bit monochrome pixel stream.
- Issues the two per-frame interrupt requests (mid-screen, end-of-screen) consumed by the CPU interrupt logic.

Parameters:
- H_TOTAL, 320, pixel clocks per line (0..319)
- V_TOTAL, 262, lines per frame (0..261)
- VRAM_BASE, 13'h0400, RAM offset of bitmap (CPU 0x2400)
- IRQ_MID_LINE, 96, line that raises Irq_Mid
- IRQ_END_LINE, 224, line that raises Irq_End

Ports:
- Clock  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- Pix_En  in  1  pixel clock enable; all state advances only when high
- Vid_Addr  out  13  registered RAM read address (video port)
- Vid_Data  in  8  RAM read data, valid one Clock after Vid_Addr changes
- Video  out  1  pixel, forced 0 during blank
- HSync_n  out  1  low for H 272..303
- VSync_n  out  1  low for V 236..239
- HBlank  out  1  high for H >= 256
- VBlank  out  1  high for V >= 224
- Irq_Mid  out  1  one-Clock pulse
- Irq_End  out  1  one-Clock pulse
- HCount  out  9  current H
- VCount  out  9  current V

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - H=0, V=0, shift register=0, Vid_Addr=VRAM_BASE.
  - Video=0, HSync_n=1, VSync_n=1, HBlank=0, VBlank=0, Irq_Mid=0, Irq_End=0.
- Counters: on Pix_En, H increments; at H=H_TOTAL-1, H becomes 0 and V increments; V wraps from V_TOTAL-1 to 0.
- Sync and blank: registered and decoded from the next counter value, so they align with HCount/VCount.
- Fetch column: C = ((H+3) mod H_TOTAL) >> 3.
- Fetch line: L = V+1 (wrapping to 0) when H >= H_TOTAL-3, else L = V.
- Address update: on Pix_En with H[2:0]==5, if C<32 and L<224, Vid_Addr <= VRAM_BASE + L*32 + C. Otherwise Vid_Addr holds and a fetch-valid flag is cleared.
- Shift load: on Pix_En with H[2:0]==7:
  - fetch-valid: shift register <= Vid_Data;
  - not fetch-valid: shift register <= 0.
- Shift: on all other Pix_En edges, shift register >>= 1 with zero fill.
- Video = shreg[0] & ~HBlank & ~VBlank.
- Result: the pixel at H=8k+b is bit b of byte k, where k = C, the fetch column.
- Pix_En rate: any rate up to every Clock is legal. Vid_Addr is stable for at least 2 Pix_En periods, which covers the 1-Clock RAM latency.
- Irq_Mid: asserted for exactly one Clock on the Pix_En edge entering H=0 of line IRQ_MID_LINE.
- Irq_End: same rule, on line IRQ_END_LINE.
- Interrupt independence: the two IRQs never coincide. A pulse is not repeated if Pix_En stalls.
- Address width: L*32+C is at most 0x1BFF. Adding VRAM_BASE stays within 13 bits, with a maximum of 0x1FFF and no wrap.
- Reset mid-line: all outputs return to their reset values immediately. The first line after release starts at H=0, V=0 with a valid fetch of byte 0 only from the next line. Line 0 shows blank-zero pixels, which is acceptable.

Decomposition:
- Shared package gunfight_video_pkg holds:
  - timing constants: H_ACTIVE=256, HS_START=272, HS_END=303, V_ACTIVE=224, VS_START=236, VS_END=239, BYTES_PER_LINE=32;
  - the VRAM_BASE default.
- One natural sub-module, gunfight_raster_counter: H/V counters plus sync/blank decode. Fetch, shifter and IRQ logic stay in the top level.

Test Plan:
- Reset with Pix_En=1 every Clock, run a full frame → exactly 320*262 = 83840 Pix_En per frame; HSync_n low 32 pixels per line; VSync_n low on 4 lines; VBlank rises at V=224.
- RAM model with byte at 0x0400 = 8'hA5, others 0 → line 0 pixels H0..7 = 1,0,1,0,0,1,0,1; all other pixels 0.
- Byte at 0x0400+223*32+31 = 0x1FFF set to 8'hFF → line 223 H248..255 are 1; Vid_Addr never exceeds 13'h1FFF.
- Pix_En every 3rd Clock → pixel pattern identical to the every-Clock run, with Vid_Addr stable ≥ 2 Pix_En periods per fetch.
- Run two frames → Irq_Mid pulses once at V=96, H=0 and Irq_End once at V=224, H=0, each 1 Clock wide, twice total.
- Assert Reset_n low at H=150, V=100 → all outputs take reset values asynchronously; after release HCount=0, VCount=0 and Video=0 for line 0.
